// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232 receiver/transmitter pair: state encoding,
// default line polarity and frame-length helper.
package rs232_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStartChk = 3'd1,
        StDataSh   = 3'd2,
        StParChk   = 3'd3,
        StStopChk  = 3'd4,
        StWaitIdle = 3'd5
    } rs232_state_e;

    // Idle low, start high, matching the team transmitter.
    localparam bit IDLE_LEVEL_DEFAULT = 1'b0;

    // Total bits on the wire: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input bit parity_en);
        return 32'd2 + data_bits + (parity_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/rs232_sync2.sv
// Two-flop synchroniser for an asynchronous pad input; reset value is
// configurable so the output can rest at the line's idle level.
module rs232_sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rs232_rx.sv
// Oversampling asynchronous serial receiver with single-entry holding register.
// Define RS232_RX_PARITY_EN to add an even-parity bit and the PARITY_ERR output.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 CLK_RX,
    input  logic                 RST,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 FULL,
    input  logic                 RD_EN,
    output logic                 DONE,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
`ifdef RS232_RX_PARITY_EN
    ,
    output logic                 PARITY_ERR
`endif
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
    localparam logic             StartLvl = ~IDLE_LEVEL;

    logic rx_s;

    rs232_sync2 #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk_i  (CLK_RX),
        .rst_ni (RST),
        .d_i    (RX),
        .q_o    (rx_s)
    );

    rs232_state_e         state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 full_q, full_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 load;
`ifdef RS232_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        ferr_d    = 1'b0;
        load      = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (rx_s == StartLvl) begin
                    tick_d  = '0;
                    state_d = StStartChk;
                end
            end
            StStartChk: begin
                if (tick_q == TickHalf) begin
                    if (rx_s == StartLvl) begin
                        tick_d   = '0;
                        bitcnt_d = '0;
                        state_d  = StDataSh;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StDataSh: begin
                if (tick_q == TickLast) begin
                    shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    tick_d   = '0;
                    if (bitcnt_q == BitLast) begin
`ifdef RS232_RX_PARITY_EN
                        state_d = StParChk;
`else
                        state_d = StStopChk;
`endif
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`ifdef RS232_RX_PARITY_EN
            StParChk: begin
                if (tick_q == TickLast) begin
                    // Even parity: data plus parity bit must XOR to zero.
                    par_bad_d = ^{rx_s, shreg_q};
                    tick_d    = '0;
                    state_d   = StStopChk;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif
            StStopChk: begin
                if (tick_q == TickLast) begin
                    if (rx_s == IDLE_LEVEL) begin
                        state_d = StIdle;
`ifdef RS232_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
`else
                        load = 1'b1;
`endif
                    end else begin
                        // A bad stop bit outranks a parity error.
                        ferr_d  = 1'b1;
                        state_d = StWaitIdle;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (rx_s == IDLE_LEVEL) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;

        if (RD_EN && full_q) begin
            full_d    = 1'b0;
            overrun_d = 1'b0;
        end

        if (load) begin
            if (!full_q || RD_EN) begin
                data_d = shreg_q;
                full_d = 1'b1;
                done_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_RX or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            full_q    <= full_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
`ifdef RS232_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign DATA      = data_q;
    assign FULL      = full_q;
    assign DONE      = done_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = overrun_q;
`ifdef RS232_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx at OVERSAMPLE=16, idle-low line, 8 data bits.
// Parity cases are built only when RS232_RX_PARITY_EN is defined.
module tb_rs232_rx;
    import rs232_pkg::*;

`ifdef RS232_RX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif
    localparam int FrameLen = int'(frame_bits(8, ParEn));
    // 2 sync + 1 idle detect + 8 to start centre + 16 per remaining bit.
    localparam int DoneLat  = 11 + 16 * (FrameLen - 1);

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rd_en;
    logic [7:0] data;
    logic       full;
    logic       done;
    logic       frame_err;
    logic       overrun;
`ifdef RS232_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rs232_rx #(
        .OVERSAMPLE (16),
        .IDLE_LEVEL (1'b0),
        .DATA_BITS  (8)
    ) dut (
        .CLK_RX    (clk),
        .RST       (rst_n),
        .RX        (rx),
        .DATA      (data),
        .FULL      (full),
        .RD_EN     (rd_en),
        .DONE      (done),
        .FRAME_ERR (frame_err),
        .OVERRUN   (overrun)
`ifdef RS232_RX_PARITY_EN
        ,
        .PARITY_ERR (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line_bit(input int b, input logic [7:0] d, input logic par,
                                      input logic stop);
        if (b == 0) return 1'b1;
        if (b <= 8) return d[b-1];
`ifdef RS232_RX_PARITY_EN
        if (b == 9) return par;
        if (b == 10) return stop;
`else
        if (b == 9) return stop;
`endif
        return 1'b0;
    endfunction

    // Drives one frame; start edge placed just after a clock edge. ncyc > 0 cuts it short.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input bit bad_par,
                              input bit rd_at_done, input int ncyc, output int done_at,
                              output int n_done, output int n_ferr, output int n_perr);
        logic par;
        int   last;
        par     = (^d) ^ bad_par;
        last    = (ncyc > 0) ? ncyc : FrameLen * 16 - 1;
        done_at = -1;
        n_done  = 0;
        n_ferr  = 0;
        n_perr  = 0;
        @(posedge clk); #1;
        rx = 1'b1;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = n;
            end
            if (frame_err) n_ferr++;
`ifdef RS232_RX_PARITY_EN
            if (parity_err) n_perr++;
`endif
            rx = line_bit(n / 16, d, par, stop_lvl);
            if (rd_at_done) rd_en = (n == DoneLat - 1);
        end
        rd_en = 1'b0;
    endtask

    task automatic run_idle(input int ncyc, output int n_done, output int n_ferr);
        n_done = 0;
        n_ferr = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (frame_err) n_ferr++;
        end
    endtask

    task automatic read_byte();
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        int at, nd, nf, np, nd2, nf2;
        rst_n = 1'b0;
        rx    = 1'b0;
        rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(data), 32'h0);
        check_eq("rst_full", 32'(full), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_ferr", 32'(frame_err), 32'h0);
        check_eq("rst_ovr", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        run_idle(5, nd, nf);

        // Basic frame and latency.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("a5_lat", 32'(at), 32'(DoneLat));
        check_eq("a5_ndone", 32'(nd), 32'd1);
        check_eq("a5_ferr", 32'(nf), 32'd0);
        check_eq("a5_data", 32'(data), 32'hA5);
        check_eq("a5_full", 32'(full), 32'h1);

        // Short glitch must not start a frame.
        rx = 1'b1;
        run_idle(5, nd, nf);
        rx = 1'b0;
        run_idle(30, nd2, nf2);
        check_eq("gl_done", 32'(nd + nd2), 32'd0);
        check_eq("gl_ferr", 32'(nf + nf2), 32'd0);
        check_eq("gl_data", 32'(data), 32'hA5);
        read_byte();
        check_eq("rd_full", 32'(full), 32'h0);

        // Bad stop bit, then a held break before recovery.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("fe_ferr", 32'(nf), 32'd1);
        check_eq("fe_done", 32'(nd), 32'd0);
        check_eq("fe_full", 32'(full), 32'h0);
        run_idle(40, nd, nf);
        check_eq("brk_ferr", 32'(nf), 32'd0);
        rx = 1'b0;
        run_idle(4, nd, nf);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("55_lat", 32'(at), 32'(DoneLat));
        check_eq("55_data", 32'(data), 32'h55);
        read_byte();

        // Back-to-back frames with overrun.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("11_done", 32'(nd), 32'd1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("22_done", 32'(nd), 32'd0);
        check_eq("ovr_data", 32'(data), 32'h11);
        check_eq("ovr_flag", 32'(overrun), 32'h1);
        check_eq("ovr_full", 32'(full), 32'h1);
        read_byte();
        check_eq("ovr_rd_full", 32'(full), 32'h0);
        check_eq("ovr_rd_flag", 32'(overrun), 32'h0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 0, at, nd, nf, np);
        check_eq("33_data", 32'(data), 32'h33);
        check_eq("33_full", 32'(full), 32'h1);
        check_eq("33_ovr", 32'(overrun), 32'h0);
        // Load and read on the same edge while full.
        send_frame(8'h44, 1'b0, 1'b0, 1'b1, 0, at, nd, nf, np);
        check_eq("44_done", 32'(nd), 32'd1);
        check_eq("44_data", 32'(data), 32'h44);
        check_eq("44_full", 32'(full), 32'h1);

        // Reset in the middle of the data bits.
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 80, at, nd, nf, np);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mr_data", 32'(data), 32'h0);
        check_eq("mr_full", 32'(full), 32'h0);
        check_eq("mr_done", 32'(done), 32'h0);
        check_eq("mr_ovr", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        rx    = 1'b0;
        run_idle(200, nd2, nf2);
        check_eq("mr_nodone", 32'(nd + nd2), 32'd0);
        check_eq("mr_noferr", 32'(nf + nf2), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("81_lat", 32'(at), 32'(DoneLat));
        check_eq("81_data", 32'(data), 32'h81);
        check_eq("81_full", 32'(full), 32'h1);

`ifdef RS232_RX_PARITY_EN
        read_byte();
        send_frame(8'h07, 1'b0, 1'b0, 1'b0, 0, at, nd, nf, np);
        check_eq("p_ok_done", 32'(nd), 32'd1);
        check_eq("p_ok_perr", 32'(np), 32'd0);
        check_eq("p_ok_data", 32'(data), 32'h07);
        read_byte();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 0, at, nd, nf, np);
        check_eq("p_bad_perr", 32'(np), 32'd1);
        check_eq("p_bad_done", 32'(nd), 32'd0);
        check_eq("p_bad_ferr", 32'(nf), 32'd0);
        check_eq("p_bad_full", 32'(full), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
